// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel counters, syncs, active-video flag and strobes.
// The generator drives it (master) and the renderer consumes it (slave).
interface vga_timing_gen_if;
    logic [9:0] hortional_counter;
    logic [9:0] vertiacl_counter;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pix_tick;
    logic       line_tick;
    logic       frame_tick;

    modport master (
        output hortional_counter, vertiacl_counter, hsync, vsync,
               video_on, pix_tick, line_tick, frame_tick
    );

    modport slave (
        input  hortional_counter, vertiacl_counter, hsync, vsync,
               video_on, pix_tick, line_tick, frame_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: divides clk down to the pixel rate and produces
// column/line counters with registered sync, active-video and strobe decodes.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  o_vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] r_div;
    logic             r_pix_tick;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_line_tick;
    logic             r_frame_tick;

    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;
    logic             w_wrap_line;
    logic             w_wrap_frame;

    always_comb begin
        w_h_next     = r_h;
        w_v_next     = r_v;
        w_wrap_line  = 1'b0;
        w_wrap_frame = 1'b0;
        if (r_pix_tick) begin
            if (r_h == H_LAST) begin
                w_h_next    = '0;
                w_wrap_line = 1'b1;
                if (r_v == V_LAST) begin
                    w_v_next     = '0;
                    w_wrap_frame = 1'b1;
                end else begin
                    w_v_next = r_v + 10'd1;
                end
            end else begin
                w_h_next = r_h + 10'd1;
            end
        end
    end

    // Decodes are taken from the next counter values so they land on the same
    // edge as the counters and never lag them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div        <= '0;
            r_pix_tick   <= 1'b0;
            r_h          <= '0;
            r_v          <= '0;
            r_hsync      <= ~SYNC_ACT;
            r_vsync      <= ~SYNC_ACT;
            r_video_on   <= 1'b0;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_div        <= (r_div == DIV_MAX) ? '0 : r_div + DIV_W'(1);
            r_pix_tick   <= (r_div == DIV_MAX);
            r_h          <= w_h_next;
            r_v          <= w_v_next;
            r_hsync      <= (w_h_next >= HS_START && w_h_next <= HS_END) ? SYNC_ACT : ~SYNC_ACT;
            r_vsync      <= (w_v_next >= VS_START && w_v_next <= VS_END) ? SYNC_ACT : ~SYNC_ACT;
            r_video_on   <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
            r_line_tick  <= w_wrap_line;
            r_frame_tick <= w_wrap_frame;
        end
    end

    assign o_vga.hortional_counter = r_h;
    assign o_vga.vertiacl_counter  = r_v;
    assign o_vga.hsync             = r_hsync;
    assign o_vga.vsync             = r_vsync;
    assign o_vga.video_on          = r_video_on;
    assign o_vga.pix_tick          = r_pix_tick;
    assign o_vga.line_tick         = r_line_tick;
    assign o_vga.frame_tick        = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-raster instances (CLK_DIV=2 and 1)
// checked every cycle against a closed-form raster model plus literal pins.
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;   // 32
    localparam int VT = VA + VFP + VS + VBP;   // 17

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if vga2();
    vga_timing_gen_if vga1();

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_ACT(1'b0)
    ) u_div2 (.clk(clk), .reset(reset), .o_vga(vga2));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_ACT(1'b0)
    ) u_div1 (.clk(clk), .reset(reset), .o_vga(vga1));

    int tests = 0;
    int fails = 0;
    int n     = 0;      // clk edges seen since reset release
    int hrun2 = 0, hrun1 = 0, vrun2 = 0, vrun1 = 0;
    int fcnt2 = 0, fcnt1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_unit(input string tag, input int d,
                              input logic [9:0] h, input logic [9:0] v,
                              input logic hs, input logic vs, input logic vid,
                              input logic pt, input logic lt, input logic ft);
        int p, eh, ev;
        logic adv, ehs, evs, evid, ept, elt, eft;
        if (!reset) begin
            eh = 0; ev = 0; ehs = 1; evs = 1; evid = 0; ept = 0; elt = 0; eft = 0;
        end else begin
            p    = (n - 1) / d;
            eh   = p % HT;
            ev   = (p / HT) % VT;
            ept  = (n % d == 0);
            adv  = (n >= 2) && ((n - 1) % d == 0);
            elt  = adv && (eh == 0);
            eft  = adv && (p % (HT * VT) == 0);
            ehs  = (eh >= HA + HFP && eh < HA + HFP + HS) ? 1'b0 : 1'b1;
            evs  = (ev >= VA + VFP && ev < VA + VFP + VS) ? 1'b0 : 1'b1;
            evid = (eh < HA) && (ev < VA);
        end
        chk({tag, ".col"},        32'(h),   32'(eh));
        chk({tag, ".line"},       32'(v),   32'(ev));
        chk({tag, ".hsync"},      32'(hs),  32'(ehs));
        chk({tag, ".vsync"},      32'(vs),  32'(evs));
        chk({tag, ".video_on"},   32'(vid), 32'(evid));
        chk({tag, ".pix_tick"},   32'(pt),  32'(ept));
        chk({tag, ".line_tick"},  32'(lt),  32'(elt));
        chk({tag, ".frame_tick"}, 32'(ft),  32'(eft));
    endtask

    // Length of each low sync pulse, measured in clk cycles.
    task automatic track_run(input string name, input logic sig, inout int run, input int want);
        if (!reset) begin
            run = 0;
        end else if (sig == 1'b0) begin
            run++;
        end else begin
            if (run != 0) chk(name, run, want);
            run = 0;
        end
    endtask

    task automatic track_frame(input string name, input logic ft, inout int cnt,
                               input int first_n, input int second_n);
        if (!reset) begin
            cnt = 0;
        end else if (ft) begin
            if (cnt == 0) chk({name, ".first"}, n, first_n);
            else if (cnt == 1) chk({name, ".second"}, n, second_n);
            cnt++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) n++;
            else n = 0;
            #2;
            check_unit("d2", 2, vga2.hortional_counter, vga2.vertiacl_counter, vga2.hsync,
                       vga2.vsync, vga2.video_on, vga2.pix_tick, vga2.line_tick, vga2.frame_tick);
            check_unit("d1", 1, vga1.hortional_counter, vga1.vertiacl_counter, vga1.hsync,
                       vga1.vsync, vga1.video_on, vga1.pix_tick, vga1.line_tick, vga1.frame_tick);
            if (reset && n == 1) begin
                chk("pin.first_col",   32'(vga2.hortional_counter), 0);
                chk("pin.first_video", 32'(vga2.video_on), 1);
                chk("pin.first_hsync", 32'(vga2.hsync), 1);
                chk("pin.first_vsync", 32'(vga2.vsync), 1);
            end
            if (reset && n == 20) chk("pin.d2_col_at20", 32'(vga2.hortional_counter), 9);
            if (reset && n == 33) begin
                chk("pin.d1_line_at33",  32'(vga1.vertiacl_counter), 1);
                chk("pin.d1_ltick_at33", 32'(vga1.line_tick), 1);
            end
            if (reset && n == 64) begin
                chk("pin.d2_col_at64",   32'(vga2.hortional_counter), 31);
                chk("pin.d2_ltick_at64", 32'(vga2.line_tick), 0);
            end
            if (reset && n == 65) begin
                chk("pin.d2_line_at65",  32'(vga2.vertiacl_counter), 1);
                chk("pin.d2_ltick_at65", 32'(vga2.line_tick), 1);
            end
            track_run("d2.hsync_width", vga2.hsync, hrun2, 12);
            track_run("d1.hsync_width", vga1.hsync, hrun1, 6);
            track_run("d2.vsync_width", vga2.vsync, vrun2, 128);
            track_run("d1.vsync_width", vga1.vsync, vrun1, 64);
            track_frame("d2.frame_tick_at", vga2.frame_tick, fcnt2, 1089, 2177);
            track_frame("d1.frame_tick_at", vga1.frame_tick, fcnt1, 545, 1089);
        end
    end

    initial begin
        logic found;
        found = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2300) @(negedge clk);

        // Reset while both syncs of the CLK_DIV=2 unit are asserted.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (vga2.hortional_counter == 10'd22 && vga2.vertiacl_counter == 10'd12) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_reset.reached_target", 32'(found), 1);
        if (found) begin
            chk("mid_reset.pre_hsync", 32'(vga2.hsync), 0);
            chk("mid_reset.pre_vsync", 32'(vga2.vsync), 0);
        end
        reset = 1'b0;
        #1;
        chk("async.d2_col",    32'(vga2.hortional_counter), 0);
        chk("async.d2_line",   32'(vga2.vertiacl_counter), 0);
        chk("async.d2_hsync",  32'(vga2.hsync), 1);
        chk("async.d2_vsync",  32'(vga2.vsync), 1);
        chk("async.d2_video",  32'(vga2.video_on), 0);
        chk("async.d2_pix",    32'(vga2.pix_tick), 0);
        chk("async.d1_col",    32'(vga1.hortional_counter), 0);
        chk("async.d1_pix",    32'(vga1.pix_tick), 0);
        chk("async.d1_ticks",  32'({vga1.line_tick, vga1.frame_tick}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (1200) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the VGA path: generates the horizontal/vertical pixel counters consumed by the pixel/game renderer, plus hsync/vsync, the active-video flag and per-line/per-frame strobes.
- Runs from the board clock with an internal pixel-rate divider. Default is 640x480@60 Hz with a 25 MHz pixel rate from a 50 MHz clk.
- frame_tick is the frame-rate update strobe for game-object motion logic.

Parameters:
- CLK_DIV, 2, clk cycles per pixel (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACT, 0, asserted level of hsync/vsync

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- hortional_counter  out  10  current pixel column, 0..H_TOTAL-1
- vertiacl_counter  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level SYNC_ACT when asserted
- vsync  out  1  vertical sync, level SYNC_ACT when asserted
- video_on  out  1  high when column < H_ACTIVE and line < V_ACTIVE
- pix_tick  out  1  one-clk pulse, high in the cycle where the counters advance on the next edge
- line_tick  out  1  one-clk pulse, first clk cycle of each new line
- frame_tick  out  1  one-clk pulse, first clk cycle of each new frame

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async, reset=0):
  - div counter = 0; hortional_counter = 0; vertiacl_counter = 0
  - hsync = vsync = ~SYNC_ACT
  - video_on = 0; pix_tick = 0; line_tick = 0; frame_tick = 0
  - A reset assertion mid-frame takes effect immediately; no partial-line completion.
- Divider: div counts 0..CLK_DIV-1 and wraps.
  - pix_tick = (div == CLK_DIV-1), registered, so it is high in exactly 1 of every CLK_DIV clk cycles.
  - With CLK_DIV=1, pix_tick is constantly high after the first post-reset edge.
- Counters advance on each clk edge where pix_tick is high:
  - column increments; at H_TOTAL-1 it wraps to 0 and the line increments.
  - The line wraps from V_TOTAL-1 to 0 only when the column also wraps.
  - Counters hold between pix_ticks.
- hsync, vsync and video_on are registered decodes of the next counter values, updated on the same edge as the counters, so they are always consistent with the counter outputs (zero relative latency).
  - The first clk edge after reset release loads the decode of (0,0): video_on = 1, syncs inactive.
  - hsync asserted iff column in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751.
  - vsync asserted iff line in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = 490..491 (whole lines, column-independent).
- line_tick: high for the single clk cycle immediately after the edge on which the column wraps to 0.
- frame_tick: high for the single clk cycle immediately after the edge on which (column, line) wraps to (0,0). It coincides with that cycle's line_tick.
  - No strobe is issued for the initial (0,0) after reset; the first frame_tick follows the first complete frame.
- Widths: 10-bit counters. Parameter sets with H_TOTAL or V_TOTAL > 1024 are illegal; flag with an elaboration-time check.
- No outputs are combinational from inputs.

Test Plan:
1. Reset state:
   - Stimulus: hold reset=0 for 5 clk, then release.
   - Required: during reset, all outputs equal the reset values above. After the first edge, counters = (0,0), video_on = 1, hsync = vsync = 1.
2. Pixel rate:
   - Stimulus: CLK_DIV=2, run 20 clk.
   - Required: pix_tick toggles 0/1 each cycle; hortional_counter steps 0,0,1,1,2,2…; reaches 9 after 20 clk.
3. Horizontal timing:
   - Stimulus: run one full line.
   - Required: video_on falls when column = 640; hsync = 0 exactly for columns 656..751 (96 pixels = 192 clk); column wraps 799->0; vertiacl_counter becomes 1; line_tick is one clk wide in the first cycle at column 0.
4. Frame timing:
   - Stimulus: run 2 frames.
   - Required: vsync = 0 exactly for lines 490..491 (1600 pixels); frame_tick pulses are 840000 clk apart (800*525*2); the first frame_tick comes 840000 clk after the first post-reset edge.
5. Reset mid-operation:
   - Stimulus: assert reset at column 700, line 490 (hsync and vsync both asserted).
   - Required: same-cycle async return of counters to 0, syncs to 1, video_on to 0, ticks to 0. After release, normal sequencing restarts at (0,0).
6. CLK_DIV=1 corner:
   - Stimulus: rebuild with CLK_DIV=1, run one frame.
   - Required: counters advance every clk; frame period = 420000 clk; hsync width = 96 clk; line_tick and frame_tick remain single-cycle.
